franken_dmem_responder: RTL and testbench



---
 rtl/franken_dmem_pkg.sv | 18 +
 rtl/dmem_byte_ram.sv | 42 ++++
 rtl/franken_dmem_responder.sv | 153 +++++++++++++++
 tb/tb_franken_dmem_responder.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/franken_dmem_pkg.sv
// franken_dmem_pkg: shared types and constants
// for the Franken data-memory responder.
package franken_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: 4-lane byte-write word RAM with
// a registered, write-first read port.
module dmem_byte_ram
  import franken_dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [LANES-1:0] be,
  input  logic [AW-1:0]    idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int n = 0; n < LANES; n++) begin
        if (be[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  // Read returns the post-write word so a store
  // response already shows the merged lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      for (int n = 0; n < LANES; n++) begin
        rdata[8*n +: 8] <= (we && be[n]) ?
          wdata[8*n +: 8] : mem[idx][8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/franken_dmem_responder.sv
// franken_dmem_responder: serialized load/store target
// with wait states; DMEM_RANGE_CHECK_EN adds rsp_err.
module franken_dmem_responder
  import franken_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rsp_valid
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        rsp_err
`endif
);

  localparam int AW = idx_w(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;

  logic [31:0] a_s;
  logic [31:0] wd_s;
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        fire;
  logic        ok;
  logic [31:0] ram_rd;

  // With zero wait states the RAM sees the live
  // request on the accepting edge.
  always_comb begin
    a_s  = addr_q;
    wd_s = wd_q;
    we_s = we_q;
    be_s = be_q;
    if (state == IDLE) begin
      a_s  = addr;
      wd_s = write_data;
      we_s = mem_write;
      be_s = byte_enable;
    end
  end

  assign off  = a_s - BASE_ADDR;
  assign idx  = AW'(off >> 2);
  assign fire = reset &&
    (((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
     ((state == WAIT) && (cnt == '0)));

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN =
    33'(DEPTH_WORDS) * 33'd4;
  logic err_q;

  assign ok = ({1'b0, off} < SPAN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else if (fire) begin
      err_q   <= !ok;
      rsp_err <= !ok;
    end else begin
      rsp_err <= 1'b0;
    end
  end

  assign read_data = err_q ? '0 : ram_rd;
`else
  assign ok        = 1'b1;
  assign read_data = ram_rd;
`endif

  dmem_byte_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .en    (fire),
    .we    (we_s && ok),
    .be    (be_s),
    .idx   (idx),
    .wdata (wd_s),
    .rdata (ram_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wd_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= addr;
            we_q      <= mem_write;
            be_q      <= byte_enable;
            wd_q      <= write_data;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_franken_dmem_responder.sv
// tb_franken_dmem_responder: random + directed bench
// for two responder instances (1 and 0 wait states).
module tb_franken_dmem_responder;

  localparam int          DEP  [2] = '{64, 16};
  localparam int          WS   [2] = '{1, 0};
  localparam bit [31:0]   BASE [2] = '{32'h0, 32'h400};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv  [2];
  logic        rr  [2];
  logic        mw  [2];
  logic        rsv [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic [3:0]  be  [2];
`ifdef DMEM_RANGE_CHECK_EN
  logic        re  [2];
`endif

  int checks = 0;
  int errors = 0;

  bit [31:0] m0 [int];
  bit [31:0] m1 [int];

  always #5 clk = ~clk;

  franken_dmem_responder #(
    .DEPTH_WORDS (64),
    .WAIT_STATES (1),
    .BASE_ADDR   (32'h0)
  ) u_a (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (rv[0]),
    .req_ready   (rr[0]),
    .addr        (ad[0]),
    .mem_write   (mw[0]),
    .byte_enable (be[0]),
    .write_data  (wd[0]),
    .read_data   (rd[0]),
    .rsp_valid   (rsv[0])
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .rsp_err     (re[0])
`endif
  );

  franken_dmem_responder #(
    .DEPTH_WORDS (16),
    .WAIT_STATES (0),
    .BASE_ADDR   (32'h400)
  ) u_b (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (rv[1]),
    .req_ready   (rr[1]),
    .addr        (ad[1]),
    .mem_write   (mw[1]),
    .byte_enable (be[1]),
    .write_data  (wd[1]),
    .read_data   (rd[1]),
    .rsp_valid   (rsv[1])
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .rsp_err     (re[1])
`endif
  );

  // Reference: flat word store indexed by offset
  // modulo the RAM span, with optional range error.
  function automatic void mdl(
    input  int        d,
    input  bit [31:0] a,
    input  bit        w,
    input  bit [3:0]  b,
    input  bit [31:0] dat,
    output bit [31:0] r,
    output bit        e
  );
    longint span = longint'(DEP[d]) * 4;
    longint off  = longint'(a) - longint'(BASE[d]);
    int     idx  = int'((((off % span) + span) % span) / 4);
    bit [31:0] word;
`ifdef DMEM_RANGE_CHECK_EN
    e = (off < 0) || (off >= span);
`else
    e = 1'b0;
`endif
    r = '0;
    if (e) return;
    if (d == 0) word = m0.exists(idx) ? m0[idx] : '0;
    else        word = m1.exists(idx) ? m1[idx] : '0;
    if (w) begin
      for (int n = 0; n < 4; n++)
        if (b[n]) word[8*n +: 8] = dat[8*n +: 8];
      if (d == 0) m0[idx] = word;
      else        m1[idx] = word;
    end
    r = word;
  endfunction

  task automatic do_req(
    input  int          d,
    input  bit [31:0]   a,
    input  bit          w,
    input  bit [3:0]    b,
    input  bit [31:0]   dat,
    output logic [31:0] r,
    output logic        e,
    output bit [31:0]   xr,
    output bit          xe,
    output int          lat
  );
    int n = 0;
    while (rr[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d", d);
    end
    mdl(d, a, w, b, dat, xr, xe);
    rv[d] = 1'b1; ad[d] = a; mw[d] = w;
    be[d] = b;    wd[d] = dat;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        rv[d] = 1'b0;
        ad[d] = $urandom; wd[d] = $urandom;
        be[d] = 4'($urandom); mw[d] = 1'($urandom);
      end
    end while (rsv[d] !== 1'b1 && lat < 40);
    if (rsv[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d", d);
    end
    r = rd[d];
`ifdef DMEM_RANGE_CHECK_EN
    e = re[d];
`else
    e = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; ad[d] = '0; mw[d] = 1'b0;
      be[d] = '0;   wd[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rr[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_ready dut%0d got %b want 1", d, rr[d]);
      end
      checks++;
      if (rsv[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_rsp dut%0d got %b want 0", d, rsv[d]);
      end
      checks++;
      if (rd[d] !== 32'h0) begin
        errors++;
        $display("FAIL rst_rdata dut%0d got %h want 0", d, rd[d]);
      end
`ifdef DMEM_RANGE_CHECK_EN
      checks++;
      if (re[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_err dut%0d got %b want 0", d, re[d]);
      end
`endif
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    do_req(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL st_rdata got %h want deadbeef", r);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL st_lat got %0d want 2", lat);
    end
    do_req(0, 32'h10, 1'b0, 4'h1, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ld_rdata got %h want deadbeef", r);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL ld_lat got %0d want 2", lat);
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    do_req(0, 32'h10, 1'b1, 4'b0100, 32'h00AB0000, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'hDEABBEEF) begin
      errors++; $display("FAIL lane_st got %h want deabbeef", r);
    end
    do_req(0, 32'h12, 1'b0, 4'h0, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'hDEABBEEF) begin
      errors++; $display("FAIL lane_ld got %h want deabbeef", r);
    end
    do_req(0, 32'h10, 1'b1, 4'b0000, 32'h01234567, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'hDEABBEEF) begin
      errors++; $display("FAIL be0_st got %h want deabbeef", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    do_req(1, BASE[1], 1'b1, 4'hF, 32'hCAFEF00D, r, e, xr, xe, lat);
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL b2b_lat got %0d want 1", lat);
    end
    @(posedge clk); #1;
    rv[1] = 1'b1; ad[1] = BASE[1]; mw[1] = 1'b0; be[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsv[1] !== 1'((i % 2) == 0)) begin
        errors++; $display("FAIL b2b_rsp cyc%0d got %b", i, rsv[1]);
      end
      checks++;
      if (rr[1] !== 1'((i % 2) == 1)) begin
        errors++; $display("FAIL b2b_ready cyc%0d got %b", i, rr[1]);
      end
      if ((i % 2) == 0) begin
        checks++;
        if (rd[1] !== 32'hCAFEF00D) begin
          errors++;
          $display("FAIL b2b_rdata cyc%0d got %h want cafef00d", i, rd[1]);
        end
      end
    end
    rv[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    bit seen = 1'b0;
    do_req(0, 32'h20, 1'b1, 4'hF, 32'h11111111, r, e, xr, xe, lat);
    @(posedge clk); #1;
    rv[0] = 1'b1; ad[0] = 32'h20; mw[0] = 1'b1;
    be[0] = 4'hF; wd[0] = 32'h22222222;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rr[0] !== 1'b1) begin
      errors++; $display("FAIL mid_ready got %b want 1", rr[0]);
    end
    checks++;
    if (rd[0] !== 32'h0) begin
      errors++; $display("FAIL mid_rdata got %h want 0", rd[0]);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsv[0] === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL mid_rsp got 1 want 0");
    end
    do_req(0, 32'h20, 1'b0, 4'hF, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'h11111111) begin
      errors++; $display("FAIL mid_ld got %h want 11111111", r);
    end
  endtask

  task automatic test_range();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    bit [31:0] top = BASE[0] + DEP[0] * 4;
    do_req(0, BASE[0], 1'b1, 4'hF, 32'h0BADC0DE, r, e, xr, xe, lat);
`ifdef DMEM_RANGE_CHECK_EN
    do_req(0, top, 1'b0, 4'hF, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL rng_ld got err=%b rd=%h want err=1 rd=0", e, r);
    end
    do_req(0, top, 1'b1, 4'hF, 32'h55555555, r, e, xr, xe, lat);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL rng_st got err=%b want 1", e);
    end
    do_req(0, BASE[0], 1'b0, 4'hF, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'h0BADC0DE || e !== 1'b0) begin
      errors++; $display("FAIL rng_w0 got err=%b rd=%h want 0/0badc0de", e, r);
    end
`else
    do_req(0, top, 1'b1, 4'hF, 32'h12345678, r, e, xr, xe, lat);
    do_req(0, BASE[0], 1'b0, 4'hF, 32'h0, r, e, xr, xe, lat);
    checks++;
    if (r !== 32'h12345678) begin
      errors++; $display("FAIL alias_ld got %h want 12345678", r);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] r; logic e; bit [31:0] xr; bit xe; int lat;
    bit [31:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        do_req(d, BASE[d] + 4 * k, 1'b1, 4'hF, $urandom,
               r, e, xr, xe, lat);
        checks++;
        if (r !== xr) begin
          errors++; $display("FAIL rnd_init dut%0d got %h want %h", d, r, xr);
        end
      end
      for (int i = 0; i < 40; i++) begin
        a = BASE[d] + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
        case ($urandom_range(0, 7))
          0: a = a + DEP[d] * 4;
`ifdef DMEM_RANGE_CHECK_EN
          1: a = BASE[d] - 4 * $urandom_range(1, 4);
`endif
          default: ;
        endcase
        do_req(d, a, 1'($urandom), 4'($urandom), $urandom,
               r, e, xr, xe, lat);
        checks++;
        if (r !== xr) begin
          errors++;
          $display("FAIL rnd_rdata dut%0d a=%h got %h want %h", d, a, r, xr);
        end
        checks++;
        if (lat != WS[d] + 1) begin
          errors++;
          $display("FAIL rnd_lat dut%0d got %0d want %0d", d, lat, WS[d] + 1);
        end
`ifdef DMEM_RANGE_CHECK_EN
        checks++;
        if (e !== xe) begin
          errors++;
          $display("FAIL rnd_err dut%0d a=%h got %b want %b", d, a, e, xe);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lane();
    test_back_to_back();
    test_reset_mid();
    test_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
